// File: rtl/router_receiver_if.sv
// router_receiver_if: serial link, buffer-write and slot-release signals of router_receiver.
// master = sender / priority-calculator side, slave = router_receiver.
interface router_receiver_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int NBUF   = 7
);
  logic              rx_valid;
  logic              rx_bit;
  logic              rx_ack;
  logic              rx_nak;
  logic              buf_wr;
  logic [2:0]        buf_idx;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              buf_local;
  logic              free_vld;
  logic [2:0]        free_idx;
  logic [NBUF-1:0]   occ;
  logic              full;
  logic [7:0]        err_cnt;

  modport master (
    output rx_valid, rx_bit, free_vld, free_idx,
    input  rx_ack, rx_nak, buf_wr, buf_idx, buf_addr, buf_data, buf_local, occ, full, err_cnt
  );

  modport slave (
    input  rx_valid, rx_bit, free_vld, free_idx,
    output rx_ack, rx_nak, buf_wr, buf_idx, buf_addr, buf_data, buf_local, occ, full, err_cnt
  );
endinterface

// File: rtl/router_receiver.sv
// router_receiver: deserialises start/address/payload frames into free buffer slots and acks/naks them.
// Define ROUTER_RX_PARITY_CHECK_EN to require a trailing even-parity bit over address and payload.
module router_receiver #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int NBUF    = 7,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  router_receiver_if.slave bus
);
  localparam int FLD_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(FLD_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
`ifdef ROUTER_RX_PARITY_CHECK_EN
    PAR    = 3'd3,
`endif
    DECIDE = 3'd4
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [ADDR_W-1:0] addr_sr_r;
  logic [DATA_W-1:0] data_sr_r;
  logic              tmo_nak_r;
  logic [NBUF-1:0]   occ_r;
  logic [7:0]        err_cnt_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] data_hold_r;
`ifdef ROUTER_RX_PARITY_CHECK_EN
  logic              par_bit_r;
`endif

  logic [NBUF-1:0]   free_mask_s;
  logic [NBUF-1:0]   occ_avail_s;
  logic [NBUF-1:0]   wr_mask_s;
  logic [2:0]        low_idx_s;
  logic              par_ok_s;
  logic              wr_s;
  logic              nak_s;

  function automatic logic [2:0] lowest_free(input logic [NBUF-1:0] busy_v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (!busy_v[i]) idx = 3'(i + 1);
    end
    return idx;
  endfunction

`ifdef ROUTER_RX_PARITY_CHECK_EN
  function automatic logic even_parity_ok(input logic [ADDR_W+DATA_W:0] frame_v);
    return ~(^frame_v);
  endfunction
`endif

  // Frame FSM: start detection, field shifting and mid-frame idle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      tmo_cnt_r <= '0;
      addr_sr_r <= '0;
      data_sr_r <= '0;
      tmo_nak_r <= 1'b0;
`ifdef ROUTER_RX_PARITY_CHECK_EN
      par_bit_r <= 1'b0;
`endif
    end else begin
      tmo_nak_r <= 1'b0;
      case (state_r)
        IDLE: begin
          bit_cnt_r <= '0;
          tmo_cnt_r <= '0;
          if (bus.rx_valid && bus.rx_bit) state_r <= ADDR;
        end
        ADDR: begin
          if (bus.rx_valid) begin
            tmo_cnt_r <= '0;
            addr_sr_r <= {addr_sr_r[ADDR_W-2:0], bus.rx_bit};
            if (bit_cnt_r == ADDR_LAST) begin
              bit_cnt_r <= '0;
              state_r   <= DATA;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_nak_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            tmo_cnt_r <= '0;
            data_sr_r <= {data_sr_r[DATA_W-2:0], bus.rx_bit};
            if (bit_cnt_r == DATA_LAST) begin
              bit_cnt_r <= '0;
`ifdef ROUTER_RX_PARITY_CHECK_EN
              state_r   <= PAR;
`else
              state_r   <= DECIDE;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_nak_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
`ifdef ROUTER_RX_PARITY_CHECK_EN
        PAR: begin
          if (bus.rx_valid) begin
            tmo_cnt_r <= '0;
            par_bit_r <= bus.rx_bit;
            state_r   <= DECIDE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_nak_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
`endif
        DECIDE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Accept/drop decision during DECIDE; a slot released this same cycle is already counted as free.
  always_comb begin
    free_mask_s = '0;
    wr_mask_s   = '0;
    for (int i = 0; i < NBUF; i++) begin
      free_mask_s[i] = bus.free_vld && (bus.free_idx == 3'(i + 1));
    end
    occ_avail_s = occ_r & ~free_mask_s;
    low_idx_s   = lowest_free(occ_avail_s);
`ifdef ROUTER_RX_PARITY_CHECK_EN
    par_ok_s    = even_parity_ok({addr_sr_r, data_sr_r, par_bit_r});
`else
    par_ok_s    = 1'b1;
`endif
    wr_s  = (state_r == DECIDE) && par_ok_s && (low_idx_s != 3'd0);
    nak_s = ((state_r == DECIDE) && !wr_s) || tmo_nak_r;
    for (int i = 0; i < NBUF; i++) begin
      wr_mask_s[i] = wr_s && (low_idx_s == 3'(i + 1));
    end
  end

  // Slot occupancy, saturating nak counter and last-written address/payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r       <= '0;
      err_cnt_r   <= 8'd0;
      addr_hold_r <= '0;
      data_hold_r <= '0;
    end else begin
      occ_r <= occ_avail_s | wr_mask_s;
      if (nak_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
      if (wr_s) begin
        addr_hold_r <= addr_sr_r;
        data_hold_r <= data_sr_r;
      end
    end
  end

  assign bus.rx_ack    = wr_s;
  assign bus.rx_nak    = nak_s;
  assign bus.buf_wr    = wr_s;
  assign bus.buf_idx   = wr_s ? low_idx_s : 3'd0;
  assign bus.buf_addr  = wr_s ? addr_sr_r : addr_hold_r;
  assign bus.buf_data  = wr_s ? data_sr_r : data_hold_r;
  assign bus.buf_local = wr_s && (addr_sr_r == '0);
  assign bus.occ       = occ_r;
  assign bus.full      = &occ_r;
  assign bus.err_cnt   = err_cnt_r;
endmodule

// File: tb/tb_router_receiver.sv
// tb_router_receiver: directed and random frames against a slot-level reference model,
// with a queue-based scoreboard checked by an independent output monitor.
module tb_router_receiver;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int NBUF    = 7;
  localparam int TIMEOUT = 15;
`ifdef ROUTER_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    bit                ack;
    int                idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                loc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   busy [1:NBUF];
  int   model_err = 0;
  exp_t exp_q[$];

  router_receiver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NBUF(NBUF)) bus ();

  router_receiver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NBUF(NBUF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NBUF-1:0] model_occ();
    logic [NBUF-1:0] v;
    v = '0;
    for (int s = 1; s <= NBUF; s++) v[s-1] = busy[s];
    return v;
  endfunction

  task automatic model_nak();
    model_err = (model_err < 255) ? model_err + 1 : 255;
  endtask

  // Reference decision: apply the same-cycle release, then lowest free slot wins unless parity is bad.
  task automatic model_decide(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input bit par_bad, input int dec_free);
    exp_t e;
    e.ack = 1'b0; e.idx = 0; e.addr = a; e.data = d; e.loc = (a == '0);
    if (dec_free >= 1 && dec_free <= NBUF) busy[dec_free] = 1'b0;
    if (!par_bad) begin
      for (int s = NBUF; s >= 1; s--) if (!busy[s]) e.idx = s;
      if (e.idx != 0) begin
        busy[e.idx] = 1'b1;
        e.ack = 1'b1;
      end
    end
    if (!e.ack) model_nak();
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b, input bit gaps);
    int n;
    n = gaps ? $urandom_range(0, 3) : 0;
    repeat (n) begin
      bus.rx_valid = 1'b0;
      bus.rx_bit   = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_bit   = b;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit flip, input bit gaps, input int dec_free);
    logic [ADDR_W+DATA_W-1:0] bits;
    bits = {a, d};
    drive_bit(1'b1, gaps);
    for (int i = ADDR_W + DATA_W - 1; i >= 0; i--) drive_bit(bits[i], gaps);
    if (PAR_EN) drive_bit((^bits) ^ flip, gaps);
    // DECIDE cycle: optional release, and a stray start bit that must be ignored
    model_decide(a, d, PAR_EN && flip, dec_free);
    bus.rx_valid = 1'($urandom_range(0, 1));
    bus.rx_bit   = 1'b1;
    if (dec_free >= 0) begin
      bus.free_vld = 1'b1;
      bus.free_idx = 3'(dec_free);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.free_vld = 1'b0;
    bus.free_idx = 3'd0;
  endtask

  task automatic do_free(input int k);
    bus.free_vld = 1'b1;
    bus.free_idx = 3'(k);
    if (k >= 1 && k <= NBUF) busy[k] = 1'b0;
    @(posedge clk); #1;
    bus.free_vld = 1'b0;
    bus.free_idx = 3'd0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_occ"}, 64'(bus.occ), 64'(model_occ()));
    chk({tag, "_full"}, 64'(bus.full), 64'(&model_occ()));
    chk({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'(model_err));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_ack"}, 64'(bus.rx_ack), 64'd0);
    chk({tag, "_rx_nak"}, 64'(bus.rx_nak), 64'd0);
    chk({tag, "_buf_wr"}, 64'(bus.buf_wr), 64'd0);
    chk({tag, "_buf_idx"}, 64'(bus.buf_idx), 64'd0);
    chk({tag, "_buf_local"}, 64'(bus.buf_local), 64'd0);
    chk({tag, "_buf_addr"}, 64'(bus.buf_addr), 64'd0);
    chk({tag, "_buf_data"}, 64'(bus.buf_data), 64'd0);
    chk({tag, "_occ"}, 64'(bus.occ), 64'd0);
    chk({tag, "_full"}, 64'(bus.full), 64'd0);
    chk({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'd0);
  endtask

  // Monitor: every ack/nak/write is matched against the oldest expected outcome.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (bus.rx_ack || bus.rx_nak || bus.buf_wr)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rx_ack=%0b rx_nak=%0b buf_wr=%0b with nothing expected",
                 bus.rx_ack, bus.rx_nak, bus.buf_wr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rx_ack", 64'(bus.rx_ack), 64'(e.ack));
        chk("sb_rx_nak", 64'(bus.rx_nak), 64'(!e.ack));
        chk("sb_buf_wr", 64'(bus.buf_wr), 64'(e.ack));
        if (e.ack) begin
          chk("sb_buf_idx", 64'(bus.buf_idx), 64'(e.idx));
          chk("sb_buf_addr", 64'(bus.buf_addr), 64'(e.addr));
          chk("sb_buf_data", 64'(bus.buf_data), 64'(e.data));
          chk("sb_buf_local", 64'(bus.buf_local), 64'(e.loc));
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int nf;
    int df;
    bus.rx_valid = 1'b0;
    bus.rx_bit   = 1'b0;
    bus.free_vld = 1'b0;
    bus.free_idx = 3'd0;
    for (int s = 1; s <= NBUF; s++) busy[s] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // local-address frame into slot 1
    send_frame(12'h000, 32'hDEADBEEF, 1'b0, 1'b0, -1);
    check_status("first_frame");

    // fill all slots, then one more frame must be dropped
    do_free(1);
    for (int f = 0; f < NBUF; f++) send_frame(12'h801, 32'(32'h1000_0000 + f), 1'b0, 1'b0, -1);
    check_status("filled");
    send_frame(12'h801, 32'hCAFEF00D, 1'b0, 1'b0, -1);
    check_status("overflow");

    // release of slot 3 in the DECIDE cycle is reused at once
    send_frame(12'h123, 32'h0BADCAFE, 1'b0, 1'b0, 3);
    check_status("free_and_write");

`ifdef ROUTER_RX_PARITY_CHECK_EN
    do_free(5);
    send_frame(12'h0F0, 32'h12345678, 1'b1, 1'b0, -1);
    check_status("parity_bad");
`endif

    // mid-address idle timeout, then a clean frame into the lowest free slot
    do_free(6);
    do_free(2);
    drive_bit(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive_bit(1'($urandom), 1'b0);
    bus.rx_valid = 1'b0;
    exp_q.push_back('{ack: 1'b0, idx: 0, addr: '0, data: '0, loc: 1'b0});
    model_nak();
    repeat (TIMEOUT + 3) begin @(posedge clk); #1; end
    check_status("timeout");
    send_frame(12'hA5A, 32'h55AA55AA, 1'b0, 1'b0, -1);
    check_status("after_timeout");

    // reset in the middle of the payload discards the frame silently
    drive_bit(1'b1, 1'b0);
    for (int i = 0; i < ADDR_W + 10; i++) drive_bit(1'($urandom), 1'b0);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    for (int s = 1; s <= NBUF; s++) busy[s] = 1'b0;
    model_err = 0;
    #2;
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(12'h3C3, 32'hFEEDFACE, 1'b0, 1'b0, -1);
    check_status("after_reset");

    // randomized traffic with releases, bit gaps and occasional bad parity
    for (int it = 0; it < 80; it++) begin
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) do_free($urandom_range(0, NBUF));
      a  = ($urandom_range(0, 3) == 0) ? '0 : ADDR_W'($urandom);
      d  = $urandom;
      df = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NBUF)) : -1;
      send_frame(a, d, $urandom_range(0, 7) == 0, 1'($urandom), df);
      check_status("random");
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_receiver.md
Name: router_receiver

Overview:
- Bit-serial message receiver at a router input link; the upstream end of the buffer/priority/identifier path.
- Deserialises incoming frames (address, payload, optional parity) and writes each accepted message into a free message buffer slot (1..NBUF).
- Tracks slot occupancy and frees slots on notice of spent messages from the priority calculator.
- Returns a per-frame ack/nak to the sender.

Parameters:
- ADDR_W, 12, address field width in bits; one bit per hypercube dimension.
- DATA_W, 32, payload width in bits.
- NBUF, 7, number of message buffer slots; slot indices are 1..NBUF and 0 means none.
- TIMEOUT, 15, idle cycles tolerated mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_valid  in  1  rx_bit is valid this cycle.
- rx_bit  in  1  serial data, MSB first within each field.
- rx_ack  out  1  one-cycle pulse: frame accepted and written.
- rx_nak  out  1  one-cycle pulse: frame dropped (no free slot, parity error, or timeout).
- buf_wr  out  1  one-cycle write strobe to the buffer array.
- buf_idx  out  3  target slot (1..NBUF), valid with buf_wr.
- buf_addr  out  ADDR_W  received address, valid with buf_wr.
- buf_data  out  DATA_W  received payload, valid with buf_wr.
- buf_local  out  1  buf_addr is all zero (message is for this router), valid with buf_wr.
- free_vld  in  1  release slot free_idx this cycle.
- free_idx  in  3  slot to release (1..NBUF); 0 or >NBUF is ignored.
- occ  out  NBUF  occupancy bitmap; bit i-1 corresponds to slot i.
- full  out  1  all slots occupied.
- err_cnt  out  8  saturating count of nak events.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - occ=0, full=0, err_cnt=0.
  - rx_ack=0, rx_nak=0, buf_wr=0, buf_idx=0, buf_local=0.
  - buf_addr and buf_data are cleared to 0.
  - A partial frame in progress is discarded; no ack or nak is issued for it.
- Frame format: start bit '1', then ADDR_W address bits, then DATA_W payload bits, then 1 even-parity bit (parity only when PARITY_CHECK_EN is defined).
- Only cycles with rx_valid=1 advance the FSM; bits are sampled on the rising edge of clk.
- FSM states:
  - IDLE: a valid '1' goes to ADDR; a valid '0' is ignored (line idle).
  - ADDR: shift in ADDR_W bits; then go to DATA.
  - DATA: shift in DATA_W bits; then go to PAR if parity is enabled, else DECIDE.
  - PAR: sample 1 bit, then go to DECIDE.
  - DECIDE: exactly one cycle, regardless of rx_valid; outcomes:
    - Parity bad: rx_nak=1.
    - Else full: rx_nak=1.
    - Else: buf_wr=1, rx_ack=1, buf_idx = lowest-numbered free slot, that occ bit set.
    - All outcomes then return to IDLE.
- A start bit arriving in the DECIDE cycle is ignored. The sender must not begin the next frame until after it sees ack or nak.
- Timeout:
  - In ADDR, DATA or PAR, a counter tracks consecutive rx_valid=0 cycles.
  - When the count reaches TIMEOUT: rx_nak=1 for one cycle, go to IDLE, increment err_cnt.
  - The counter resets on every valid bit.
- Latency: buf_wr, rx_ack and rx_nak are asserted in the cycle after the last frame bit is sampled.
- Freeing:
  - free_vld=1 clears occ[free_idx-1] at the next edge.
  - Freeing an already-free slot is a no-op.
- Free and write in the same cycle:
  - DECIDE evaluates occupancy with this cycle's free already applied, so a freed slot can be reused immediately.
  - If the freed slot is the lowest free slot, the resulting occ bit is 1 (the write wins).
- full = (occ == all ones), derived combinationally from the registered occ.
- err_cnt increments on every rx_nak and saturates at 255.
- buf_addr and buf_data hold their last written value between writes.

Optional Feature:
- Macro: ROUTER_RX_PARITY_CHECK_EN.
- Defined:
  - The frame carries a trailing even-parity bit computed over the address and payload bits.
  - A mismatch causes a nak and no write; err_cnt increments.
- Undefined:
  - There is no PAR state; a frame is 1+ADDR_W+DATA_W bits.
  - Parity is never checked.

Test Plan:
- Reset, then frame with addr=12'h000, data=32'hDEADBEEF, correct parity -> buf_wr, buf_idx=1, buf_local=1, rx_ack, occ=7'b0000001.
- Seven back-to-back frames with addr=12'h801, then an eighth frame -> slots 1..7 filled in order, full=1; eighth frame gives rx_nak, no buf_wr, err_cnt=1.
- With occ full, assert free_vld with free_idx=3 in the same cycle as DECIDE -> write goes to buf_idx=3, occ stays all ones, rx_ack.
- Frame with flipped parity bit (macro defined) -> rx_nak, no write, occ unchanged, err_cnt increments.
- Drop rx_valid for 15 cycles after 10 address bits -> rx_nak, FSM returns to IDLE, next frame is received correctly into the lowest free slot.
- Assert rst mid-DATA -> all outputs 0, no ack or nak, occ=0; the following full frame is accepted into slot 1.
